// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic ARB_RD = 1'b0;
  localparam logic ARB_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM port around mem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_arbiter_if #(
    parameter int unsigned n    = 32,
    parameter int unsigned alen = 6
);

    // Fetch port
    logic              i_req;
    logic [alen-1:0]   i_addr;
    logic              i_valid;
    logic [n-1:0]      i_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [alen-1:0]   d_addr;
    logic [n-1:0]      d_wdata;
    logic [n/8-1:0]    d_be;
    logic              d_valid;
    logic [n-1:0]      d_rdata;

    // RAM port
    logic              m_en;
    logic              m_we;
    logic [alen-1:0]   m_addr;
    logic [n-1:0]      m_wdata;
    logic [n/8-1:0]    m_be;
    logic [n-1:0]      m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_valid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_valid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, m_be,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_valid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_valid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, m_be,
        output m_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the arbiter.
// MEM_ARB_RR_EN: round-robin on collision; otherwise fixed priority with D over I.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  arb_owner_t last_owner_i,
    output logic       grant_valid_o,
    output arb_owner_t grant_owner_o
);

    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_owner_o = OWN_I;
`ifdef MEM_ARB_RR_EN
        // On a collision the port that did not win last time goes next
        if (i_req_i && d_req_i) begin
            grant_owner_o = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req_i) begin
            grant_owner_o = OWN_D;
        end
`else
        if (d_req_i) begin
            grant_owner_o = OWN_D;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and load/store (D) ports.
// Define MEM_ARB_RR_EN for round-robin collision handling; default is D-over-I priority.
module mem_arbiter #(
    parameter int unsigned n    = 32,
    parameter int unsigned alen = 6
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus_io,
    output logic          busy
);

    import mem_arb_pkg::*;

    localparam int unsigned BeW = n / 8;

    arb_state_t        state_q;
    arb_owner_t        owner_q;
    logic              we_q;
    logic              m_en_q;
    logic              m_we_q;
    logic [alen-1:0]   m_addr_q;
    logic [n-1:0]      m_wdata_q;
    logic [BeW-1:0]    m_be_q;
    logic              i_valid_q;
    logic              d_valid_q;

    logic              grant_valid;
    arb_owner_t        grant_owner;

    // owner_q doubles as the round-robin pointer: it always names the last granted port
    mem_arb_pick u_pick (
        .i_req_i       (bus_io.i_req),
        .d_req_i       (bus_io.d_req),
        .last_owner_i  (owner_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            we_q      <= ARB_RD;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state_q <= ARB_ACCESS;
                        owner_q <= grant_owner;
                        m_en_q  <= 1'b1;
                        if (grant_owner == OWN_D) begin
                            we_q     <= bus_io.d_we;
                            m_we_q   <= bus_io.d_we;
                            m_addr_q <= bus_io.d_addr;
                            if (bus_io.d_we == ARB_WR) begin
                                m_wdata_q <= bus_io.d_wdata;
                                m_be_q    <= bus_io.d_be;
                            end else begin
                                m_be_q    <= '0;
                            end
                        end else begin
                            // Fetches are reads regardless of what the D port drives
                            we_q     <= ARB_RD;
                            m_we_q   <= ARB_RD;
                            m_addr_q <= bus_io.i_addr;
                            m_be_q   <= '0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    state_q   <= ARB_RESP;
                    m_en_q    <= 1'b0;
                    m_we_q    <= 1'b0;
                    m_be_q    <= '0;
                    i_valid_q <= (owner_q == OWN_I);
                    d_valid_q <= (owner_q == OWN_D);
                end
                ARB_RESP: begin
                    state_q   <= ARB_IDLE;
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus_io.m_en    = m_en_q;
    assign bus_io.m_we    = m_we_q;
    assign bus_io.m_addr  = m_addr_q;
    assign bus_io.m_wdata = m_wdata_q;
    assign bus_io.m_be    = m_be_q;

    // RAM read data arrives in RESP and is steered straight through to the owner
    assign bus_io.i_valid = i_valid_q;
    assign bus_io.i_rdata = i_valid_q ? bus_io.m_rdata : '0;
    assign bus_io.d_valid = d_valid_q;
    assign bus_io.d_rdata = (d_valid_q && (we_q != ARB_WR)) ? bus_io.m_rdata : '0;

    assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle plus directed cases.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned N    = 32;
    localparam int unsigned ALEN = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;

    mem_arbiter_if #(.n(N), .alen(ALEN)) bus ();

    mem_arbiter #(.n(N), .alen(ALEN)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] preload(input int a);
        if (a == 5)  return 32'h0050_0093;
        if (a == 16) return 32'h0;
        return {8'hA5, 8'h00, 8'(a), 8'(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous RAM: read data appears the cycle after m_en
    logic [31:0] ram [64];
    bit ram_loaded = 1'b0;
    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 64; a++) ram[a] <= preload(a);
            ram_loaded <= 1'b1;
        end else if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_be[b]) ram[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end else begin
                bus.m_rdata <= ram[bus.m_addr];
            end
        end
    end

    // Model: each grant at edge g puts the RAM access in the cycle after g and the
    // response in the cycle after g+1; the next grant can happen no earlier than g+3.
    logic [31:0] shadow [64];
    initial begin : monitor
        int cur, g;
        bit act;
        arb_owner_t own, last;
        logic mwe;
        logic [5:0] maddr, last_addr;
        logic [31:0] mwd, rexp;
        logic [3:0] mbe;
        bit e_men, e_iv, e_dv, e_busy;
        for (int a = 0; a < 64; a++) shadow[a] = preload(a);
        act = 1'b0; g = 0; own = OWN_I; last = OWN_I; last_addr = '0;
        mwe = 1'b0; maddr = '0; mwd = '0; rexp = '0; mbe = '0;
        @(posedge clock);
        cur = 1;
        forever begin
            @(negedge clock);
            e_men  = act && (cur == g);
            e_iv   = act && (cur == g + 1) && (own == OWN_I);
            e_dv   = act && (cur == g + 1) && (own == OWN_D);
            e_busy = act && (cur == g || cur == g + 1);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("m_en", 64'(bus.m_en), 64'(e_men));
            chk("m_we", 64'(bus.m_we), 64'(e_men && mwe));
            chk("m_be", 64'(bus.m_be), 64'(e_men ? mbe : 4'h0));
            chk("m_addr", 64'(bus.m_addr), 64'(last_addr));
            if (e_men && mwe) chk("m_wdata", 64'(bus.m_wdata), 64'(mwd));
            chk("i_valid", 64'(bus.i_valid), 64'(e_iv));
            chk("d_valid", 64'(bus.d_valid), 64'(e_dv));
            chk("i_rdata", 64'(bus.i_rdata), 64'(e_iv ? rexp : 32'h0));
            chk("d_rdata", 64'(bus.d_rdata), 64'(e_dv ? rexp : 32'h0));
            // Predict the next edge from the inputs now stable
            if (reset) begin
                act = 1'b0; last = OWN_I; last_addr = '0;
            end else if ((!act || cur + 1 >= g + 3) && (bus.i_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
                if (bus.i_req && bus.d_req) own = (last == OWN_D) ? OWN_I : OWN_D;
                else own = bus.d_req ? OWN_D : OWN_I;
`else
                own = bus.d_req ? OWN_D : OWN_I;
`endif
                if (own == OWN_D) begin
                    mwe = bus.d_we; maddr = bus.d_addr; mwd = bus.d_wdata;
                    mbe = bus.d_we ? bus.d_be : 4'h0;
                end else begin
                    mwe = 1'b0; maddr = bus.i_addr; mbe = 4'h0;
                end
                if (mwe) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[b]) shadow[maddr][8*b +: 8] = mwd[8*b +: 8];
                    rexp = 32'h0;
                end else begin
                    rexp = shadow[maddr];
                end
                act = 1'b1; g = cur + 1; last = own; last_addr = maddr;
            end
            cur++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic access(input bit is_d, input bit we, input logic [5:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output int lat);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd; bus.d_be = be;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (is_d ? bus.d_valid : bus.i_valid) begin
                lat = c;
                rd  = is_d ? bus.d_rdata : bus.i_rdata;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
    endtask

    initial begin : stim
        logic [31:0] rd;
        int lat, ilat, dlat, nv;
        logic [9:0] seq;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_en", 64'(bus.m_en), 64'(0));
        chk("rst_m_addr", 64'(bus.m_addr), 64'(0));
        chk("rst_i_valid", 64'(bus.i_valid), 64'(0));

        // Single fetch; d_we high must not turn it into a store
        bus.i_req = 1'b1; bus.i_addr = 6'h05; bus.d_we = 1'b1;
        tick();
        chk("fetch_m_en", 64'(bus.m_en), 64'(1));
        chk("fetch_m_addr", 64'(bus.m_addr), 64'(6'h05));
        chk("fetch_m_we", 64'(bus.m_we), 64'(0));
        tick();
        chk("fetch_valid", 64'(bus.i_valid), 64'(1));
        chk("fetch_rdata", 64'(bus.i_rdata), 64'(32'h0050_0093));
        chk("fetch_no_dvalid", 64'(bus.d_valid), 64'(0));
        bus.i_req = 1'b0; bus.d_we = 1'b0;
        tick();

        // Store with partial byte enables, then read back
        access(1'b1, 1'b1, 6'h10, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        chk("store_lat", 64'(lat), 64'(2));
        chk("store_rdata", 64'(rd), 64'(0));
        access(1'b1, 1'b0, 6'h10, 32'h0, 4'hF, rd, lat);
        chk("load_lat", 64'(lat), 64'(2));
        chk("load_rdata", 64'(rd), 64'(32'h0000_BEEF));

        // Collision; the last grant was D
        bus.i_req = 1'b1; bus.i_addr = 6'h05;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'h07;
        ilat = -1; dlat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.d_valid) begin dlat = c; bus.d_req = 1'b0; end
            if (bus.i_valid) begin ilat = c; bus.i_req = 1'b0; end
        end
`ifdef MEM_ARB_RR_EN
        chk("coll_ilat", 64'(ilat), 64'(2));
        chk("coll_dlat", 64'(dlat), 64'(5));
`else
        chk("coll_dlat", 64'(dlat), 64'(2));
        chk("coll_ilat", 64'(ilat), 64'(5));
`endif

        // Both ports held requesting from reset
        reset = 1'b1; tick(); reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 6'h03;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'h04;
        nv = 0; seq = '0;
        for (int c = 0; c < 40 && nv < 10; c++) begin
            tick();
            if (bus.i_valid || bus.d_valid) begin
                seq = {seq[8:0], bus.d_valid};
                nv++;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick(); tick();
        chk("held_count", 64'(nv), 64'(10));
`ifdef MEM_ARB_RR_EN
        chk("rr_order", 64'(seq), 64'(10'b10_1010_1010));
`else
        chk("fixed_starve", 64'(seq), 64'(10'b11_1111_1111));
`endif

        // Reset while in ACCESS drops the access
        bus.i_req = 1'b1; bus.i_addr = 6'h05;
        tick();
        chk("pre_rst_m_en", 64'(bus.m_en), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_m_en", 64'(bus.m_en), 64'(0));
        chk("mid_rst_i_valid", 64'(bus.i_valid), 64'(0));
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (bus.i_valid) lat = c;
        end
        bus.i_req = 1'b0;
        chk("reissue_lat", 64'(lat), 64'(2));
        tick();

        // Changes during ACCESS/RESP are ignored until the next IDLE
        bus.i_req = 1'b1; bus.i_addr = 6'h03;
        tick();
        bus.i_addr = 6'h09;
        chk("held_m_addr", 64'(bus.m_addr), 64'(6'h03));
        tick();
        chk("ign_i_valid", 64'(bus.i_valid), 64'(1));
        chk("ign_i_rdata", 64'(bus.i_rdata), 64'(32'hA500_0303));
        bus.i_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'h04;
        tick();
        chk("ign_idle_busy", 64'(busy), 64'(0));
        chk("ign_idle_m_en", 64'(bus.m_en), 64'(0));
        tick();
        chk("late_d_m_en", 64'(bus.m_en), 64'(1));
        chk("late_d_m_addr", 64'(bus.m_addr), 64'(6'h04));
        tick();
        chk("late_d_valid", 64'(bus.d_valid), 64'(1));
        chk("late_d_rdata", 64'(bus.d_rdata), 64'(32'hA500_0404));
        bus.d_req = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
